uart_fifo_burst_tx_mgr: RTL and testbench
=========================================

# uart_fifo_burst_tx_mgr

Parametrised FIFO-to-UART transmit manager that drains bytes from a synchronous FIFO into the UART transmitter, one frame at a time. It sits between the TX FIFO read port and the UART TX core. Over the first-generation manager it adds configurable data width, FIFO read latency, a registered data path, flow-control pause, an optional inter-frame idle gap, a completed-frame counter and a busy flag.

## Interface
- DW, 8: data width of FIFO word and UART frame payload
- RD_LAT, 1: FIFO read latency in cycles from RD_Req_sig to valid FIFO_RD_Dat; legal 1..4
- GAP_CYC, 0: idle cycles inserted after each frame (only with gap feature compiled in); legal 0..255
- CNT_W, 16: width of Byte_Cnt
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- Empty_sig  input  1  FIFO empty flag
- RD_Req_sig  output  1  FIFO read strobe, one-cycle pulse
- FIFO_RD_Dat  input  DW  FIFO read data
- Pause  input  1  high = do not start a new frame
- Tx_Dat  output  DW  registered frame payload to UART TX
- TxEn  output  1  transmit enable, held until done
- Tx_Done_sig  input  1  UART TX frame complete (pulse)
- Busy  output  1  high whenever state is not IDLE
- Byte_Cnt  output  CNT_W  count of completed frames, wraps

## Operation
- States: IDLE, RDREQ, WAIT, LOAD, SEND, GAP.
- IDLE: if Empty_sig=0 and Pause=0 → RDREQ; otherwise stay.
- RDREQ: RD_Req_sig=1 for exactly this cycle → WAIT (RD_LAT>1) or LOAD (RD_LAT=1).
- WAIT: latency counter counts RD_LAT-1 cycles → LOAD.
- LOAD: FIFO_RD_Dat captured into Tx_Dat at end of cycle → SEND.
- SEND: TxEn=1; Tx_Dat stable; on Tx_Done_sig=1 → Byte_Cnt+1 (mod 2^CNT_W), → GAP (if gap feature compiled in and GAP_CYC>0) else IDLE.
- GAP: count GAP_CYC cycles → IDLE.
- Tx_Done_sig is ignored in every state except SEND.
- Pause is sampled only in IDLE; a frame in flight always completes.
- Empty_sig is sampled only in IDLE; the block never reads an empty FIFO.
- Reset values: RD_Req_sig=0, TxEn=0, Tx_Dat=0, Busy=0, Byte_Cnt=0, state=IDLE.
- Reset mid-frame: all outputs take their reset values after the edge where RST=1. The in-flight byte is dropped and is not counted.

## Timing
- Cycle 0 IDLE with Empty_sig=0 → cycle 1 RD_Req_sig=1 → FIFO_RD_Dat sampled in cycle 1+RD_LAT → cycle 2+RD_LAT TxEn=1, Tx_Dat valid.
- Tx_Done_sig high in cycle k → TxEn=0 and Byte_Cnt updated in cycle k+1.
- Without gap, the next RD_Req_sig comes no earlier than cycle k+2. With gap, it comes no earlier than k+2+GAP_CYC.
- Busy rises in the RDREQ cycle and falls on the first IDLE cycle.

## Configuration
- UART_TX_MGR_GAP_EN
  - Defined: GAP state and gap timer are present; GAP_CYC idle cycles follow each frame.
  - Undefined: GAP state and gap timer are absent; SEND returns directly to IDLE; GAP_CYC is ignored.

## Structure
- Shared package uart_tx_pkg:
  - state enum (IDLE..GAP)
  - RD_LAT and GAP_CYC legal limits
  - latency counter width constant (2 bits) and gap counter width constant (8 bits)
- One sub-module uart_tx_gap_timer: loadable down-counter with a done flag. It is instantiated only under UART_TX_MGR_GAP_EN and reused for the WAIT latency count.

## Test plan
- RD_LAT=1, FIFO holds 0xA5, Tx_Done_sig 10 cycles after TxEn → RD_Req_sig pulse in cycle 1, TxEn in cycles 3..13, Tx_Dat=0xA5, Byte_Cnt=1.
- RD_LAT=3, DW=9, FIFO holds 0x1FF, 0x003 → TxEn first rises in cycle 5; frames sent in order; exactly 2 RD_Req_sig pulses; Byte_Cnt=2.
- Gap feature compiled in, GAP_CYC=4, three queued bytes → exactly 4 Busy-high idle cycles between each TxEn fall and the next RD_Req_sig. With the macro undefined, the next RD_Req_sig comes 2 cycles after Tx_Done_sig.
- Pause raised during SEND → current frame completes and is counted; no RD_Req_sig while Pause=1; a read resumes 1 cycle after Pause falls.
- Stray Tx_Done_sig in IDLE or LOAD → no state change, Byte_Cnt unchanged. CNT_W=4 with 17 frames → Byte_Cnt=1.
- RST=1 during SEND → next cycle TxEn=0, Tx_Dat=0, Busy=0, Byte_Cnt=0; operation restarts cleanly from IDLE.

Source files
------------

// File: rtl/uart_fifo_burst_tx_mgr_pkg.sv
// rtl/uart_fifo_burst_tx_mgr_pkg.sv - shared types and limits for the FIFO-to-UART transmit manager
// Purpose: FSM state encoding, legal parameter ranges and counter widths used by
//          uart_fifo_burst_tx_mgr and uart_tx_gap_timer.
// Ports:   none (package).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RDREQ = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam int LAT_CNT_W = 2;
  localparam int GAP_CNT_W = 8;

  localparam int RD_LAT_MIN  = 1;
  localparam int RD_LAT_MAX  = 1 << LAT_CNT_W;
  localparam int GAP_CYC_MIN = 0;
  localparam int GAP_CYC_MAX = (1 << GAP_CNT_W) - 1;

endpackage

// File: rtl/uart_fifo_burst_tx_mgr_gap_timer.sv
// rtl/uart_fifo_burst_tx_mgr_gap_timer.sv - loadable down-counter with done flag
// Purpose: counts the FIFO read-latency wait and the inter-frame idle gap.
//          Only built when UART_TX_MGR_GAP_EN is defined.
// Ports:   CLK, RST      clock, synchronous active-high reset
//          load          load load_val into the counter this cycle
//          load_val      value loaded (cycles remaining minus one)
//          done          counter has reached zero
`ifdef UART_TX_MGR_GAP_EN
module uart_tx_gap_timer
  import uart_tx_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic [GAP_CNT_W-1:0] load_val,
  output logic                 done
);

  logic [GAP_CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - GAP_CNT_W'(1);
  end

  assign done = (cnt == '0);

endmodule
`endif

// File: rtl/uart_fifo_burst_tx_mgr.sv
// rtl/uart_fifo_burst_tx_mgr.sv - drains a synchronous FIFO into the UART TX core one frame at a time
// Purpose: IDLE -> RDREQ -> (WAIT) -> LOAD -> SEND -> (GAP) -> IDLE frame sequencer.
// Option:  UART_TX_MGR_GAP_EN adds the GAP state and gap timer (GAP_CYC idle cycles per frame).
// Ports:   CLK, RST        clock, synchronous active-high reset
//          Empty_sig       FIFO empty flag (sampled in IDLE only)
//          RD_Req_sig      one-cycle FIFO read strobe
//          FIFO_RD_Dat     FIFO read data, valid RD_LAT cycles after RD_Req_sig
//          Pause           blocks the start of a new frame (sampled in IDLE only)
//          Tx_Dat, TxEn    registered payload and transmit enable to the UART core
//          Tx_Done_sig     UART frame complete pulse (honoured in SEND only)
//          Busy            state is not IDLE
//          Byte_Cnt        completed-frame counter, wraps
module uart_fifo_burst_tx_mgr
  import uart_tx_pkg::*;
#(
  parameter int DW      = 8,
  parameter int RD_LAT  = 1,
  parameter int GAP_CYC = 0,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Empty_sig,
  output logic             RD_Req_sig,
  input  logic [DW-1:0]    FIFO_RD_Dat,
  input  logic             Pause,
  output logic [DW-1:0]    Tx_Dat,
  output logic             TxEn,
  input  logic             Tx_Done_sig,
  output logic             Busy,
  output logic [CNT_W-1:0] Byte_Cnt
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_RDREQ = ST_RDREQ;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_SEND  = ST_SEND;

  // WAIT leaves when the counter hits zero, so load one less than the WAIT length (RD_LAT-1).
  localparam int LAT_LOAD = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("RD_LAT out of range");
  end
  if (GAP_CYC < GAP_CYC_MIN || GAP_CYC > GAP_CYC_MAX) begin : g_bad_gap_cyc
    $error("GAP_CYC out of range");
  end

  logic [2:0] state, state_nxt;
  logic       wait_done;

`ifdef UART_TX_MGR_GAP_EN
  localparam logic [2:0] S_GAP = ST_GAP;
  localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  logic                 tmr_load;
  logic [GAP_CNT_W-1:0] tmr_val;
  logic                 tmr_done;

  // One timer serves both waits: loaded in RDREQ for the latency, and in every
  // SEND cycle for the gap (only the last SEND load survives into GAP).
  assign tmr_load = (state == S_RDREQ) || (state == S_SEND);
  assign tmr_val  = (state == S_RDREQ) ? GAP_CNT_W'(LAT_LOAD) : GAP_CNT_W'(GAP_LOAD);

  uart_tx_gap_timer u_gap_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign wait_done = tmr_done;
`else
  logic [LAT_CNT_W-1:0] lat_cnt;

  always_ff @(posedge CLK) begin
    if (RST)
      lat_cnt <= '0;
    else if (state == S_RDREQ)
      lat_cnt <= LAT_CNT_W'(LAT_LOAD);
    else if (lat_cnt != '0)
      lat_cnt <= lat_cnt - LAT_CNT_W'(1);
  end

  assign wait_done = (lat_cnt == '0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!Empty_sig && !Pause) state_nxt = S_RDREQ;
      S_RDREQ: state_nxt = (RD_LAT > 1) ? S_WAIT : S_LOAD;
      S_WAIT:  if (wait_done) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SEND;
`ifdef UART_TX_MGR_GAP_EN
      S_SEND:  if (Tx_Done_sig) state_nxt = (GAP_CYC > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (tmr_done) state_nxt = S_IDLE;
`else
      S_SEND:  if (Tx_Done_sig) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      Tx_Dat   <= '0;
      Byte_Cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD)
        Tx_Dat <= FIFO_RD_Dat;
      if (state == S_SEND && Tx_Done_sig)
        Byte_Cnt <= Byte_Cnt + CNT_W'(1);
    end
  end

  assign RD_Req_sig = (state == S_RDREQ);
  assign TxEn       = (state == S_SEND);
  assign Busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_fifo_burst_tx_mgr.sv
// tb/tb_uart_fifo_burst_tx_mgr.sv - self-checking bench for uart_fifo_burst_tx_mgr
module tb_uart_fifo_burst_tx_mgr;

  localparam int RD_LAT_B = 3;
  localparam int CNT_W_B  = 4;
  localparam int GAP_B    = 4;
`ifdef UART_TX_MGR_GAP_EN
  localparam int GAP_EXP = GAP_B;
`else
  localparam int GAP_EXP = 0;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // instance A: DW=8, RD_LAT=1, CNT_W=16, no gap
  logic        RST_a, Empty_a, Pause_a, Done_a, RD_a, TxEn_a, Busy_a;
  logic [7:0]  Fdat_a, Tdat_a;
  logic [15:0] Cnt_a;
  // instance B: DW=9, RD_LAT=3, CNT_W=4, GAP_CYC=4
  logic        RST_b, Empty_b, Pause_b, Done_b, RD_b, TxEn_b, Busy_b;
  logic [8:0]  Fdat_b, Tdat_b;
  logic [3:0]  Cnt_b;

  uart_fifo_burst_tx_mgr #(.DW(8), .RD_LAT(1), .GAP_CYC(0), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST_a), .Empty_sig(Empty_a), .RD_Req_sig(RD_a), .FIFO_RD_Dat(Fdat_a),
    .Pause(Pause_a), .Tx_Dat(Tdat_a), .TxEn(TxEn_a), .Tx_Done_sig(Done_a), .Busy(Busy_a),
    .Byte_Cnt(Cnt_a));

  uart_fifo_burst_tx_mgr #(.DW(9), .RD_LAT(RD_LAT_B), .GAP_CYC(GAP_B), .CNT_W(CNT_W_B)) dut_b (
    .CLK(CLK), .RST(RST_b), .Empty_sig(Empty_b), .RD_Req_sig(RD_b), .FIFO_RD_Dat(Fdat_b),
    .Pause(Pause_b), .Tx_Dat(Tdat_b), .TxEn(TxEn_b), .Tx_Done_sig(Done_b), .Busy(Busy_b),
    .Byte_Cnt(Cnt_b));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- table for instance A ----------------
  typedef struct {
    bit          rst, empty, pause, done;
    logic [7:0]  dat;
    bit          e_rd, e_en, e_busy;
    logic [7:0]  e_dat;
    logic [15:0] e_cnt;
  } row_t;
  row_t tbl[$];

  task automatic add(input bit rst, input bit empty, input bit pause, input bit done,
                     input logic [7:0] dat, input bit e_rd, input bit e_en, input bit e_busy,
                     input logic [7:0] e_dat, input logic [15:0] e_cnt);
    row_t r;
    r.rst = rst; r.empty = empty; r.pause = pause; r.done = done; r.dat = dat;
    r.e_rd = e_rd; r.e_en = e_en; r.e_busy = e_busy; r.e_dat = e_dat; r.e_cnt = e_cnt;
    tbl.push_back(r);
  endtask

  // ---------------- reference model for instance B ----------------
  // Frame timeline: read strobe at m_r, TxEn from m_r+1+RD_LAT through the done
  // cycle m_k, then GAP_EXP busy idle cycles, then IDLE.
  int         cyc;
  bit         m_active;
  int         m_r, m_k, m_cnt;
  logic [8:0] m_dat, m_txdat;
  logic [8:0] fifo_q[$];
  bit         pause_drive;
  int         first_en, rd_pulses, fall_cyc, rd_after_fall;
  bit         prev_en;

  task automatic step_b(input bit stray_en);
    bit e_rd, e_en, e_busy, done_drive;
    e_rd = 0; e_en = 0; e_busy = 0; done_drive = 0;
    if (m_active && cyc > m_k + GAP_EXP) m_active = 0;
    if (m_active) begin
      e_busy = 1;
      if (cyc == m_r) begin
        e_rd  = 1;
        m_dat = fifo_q.pop_front();
      end else if (cyc >= m_r + 1 + RD_LAT_B && cyc <= m_k) begin
        e_en = 1;
        if (cyc == m_r + 1 + RD_LAT_B) begin
          m_txdat = m_dat;
          m_k     = cyc + int'($urandom_range(0, 5));
        end
        done_drive = (cyc == m_k);
      end
    end
    chk("b_rd_req", 32'(RD_b), 32'(e_rd));
    chk("b_txen",   32'(TxEn_b), 32'(e_en));
    chk("b_busy",   32'(Busy_b), 32'(e_busy));
    chk("b_tx_dat", 32'(Tdat_b), 32'(m_txdat));
    chk("b_byte_cnt", 32'(Cnt_b), 32'(m_cnt));
    if (TxEn_b === 1'b1 && first_en < 0) first_en = cyc;
    if (RD_b === 1'b1) begin
      rd_pulses++;
      if (fall_cyc >= 0) rd_after_fall = cyc - fall_cyc;
    end
    if (prev_en && TxEn_b === 1'b0) fall_cyc = cyc;
    prev_en = (TxEn_b === 1'b1);

    Fdat_b  = (m_active && cyc == m_r + RD_LAT_B) ? m_dat : 9'($urandom);
    Empty_b = (fifo_q.size() == 0);
    Pause_b = pause_drive;
    Done_b  = done_drive || (stray_en && !e_en && $urandom_range(0, 3) == 0);
    if (!m_active && !Empty_b && !Pause_b) begin
      m_active = 1;
      m_r      = cyc + 1;
      m_k      = 1 << 30;
    end
    if (done_drive) m_cnt = (m_cnt + 1) % (1 << CNT_W_B);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic reset_b();
    RST_b = 1; Empty_b = 1; Pause_b = 0; Done_b = 0; pause_drive = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("b_rst_rd_req", 32'(RD_b), 32'(0));
    chk("b_rst_txen", 32'(TxEn_b), 32'(0));
    chk("b_rst_busy", 32'(Busy_b), 32'(0));
    chk("b_rst_tx_dat", 32'(Tdat_b), 32'(0));
    chk("b_rst_byte_cnt", 32'(Cnt_b), 32'(0));
    RST_b = 0;
    fifo_q.delete();
    m_active = 0; m_cnt = 0; m_txdat = '0; cyc = 0;
    first_en = -1; rd_pulses = 0; fall_cyc = -1; rd_after_fall = -1; prev_en = 0;
  endtask

  task automatic drain_b(input bit stray_en, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || m_active) && n < budget) begin
      step_b(stray_en);
      n++;
    end
    chk("b_drain_in_budget", 32'(n < budget), 32'(1));
    for (int i = 0; i < 3; i++) step_b(stray_en);
  endtask

  initial begin
    RST_a = 1; Empty_a = 1; Pause_a = 0; Done_a = 0; Fdat_a = '0;
    RST_b = 1; Empty_b = 1; Pause_b = 0; Done_b = 0; Fdat_b = '0;

    // rst empty pause done dat | rd en busy tx_dat cnt
    add(0,1,0,0,8'h00, 0,0,0,8'h00,0);   // reset values
    add(0,0,0,0,8'hA5, 0,0,0,8'h00,0);   // cycle 0: FIFO holds A5
    add(0,1,0,0,8'hA5, 1,0,1,8'h00,0);   // cycle 1: read strobe
    add(0,1,0,1,8'hA5, 0,0,1,8'h00,0);   // LOAD with stray done
    for (int i = 3; i <= 12; i++) add(0,1,0,0,8'h00, 0,1,1,8'hA5,0);
    add(0,1,0,1,8'h00, 0,1,1,8'hA5,0);   // cycle 13: done
    add(0,1,0,0,8'h00, 0,0,0,8'hA5,1);
    add(0,1,0,1,8'h00, 0,0,0,8'hA5,1);   // stray done in IDLE
    add(0,1,0,0,8'h00, 0,0,0,8'hA5,1);
    add(0,0,0,0,8'h3C, 0,0,0,8'hA5,1);
    add(0,1,0,0,8'h3C, 1,0,1,8'hA5,1);
    add(0,1,0,0,8'h3C, 0,0,1,8'hA5,1);
    add(1,1,0,0,8'h00, 0,1,1,8'h3C,1);   // reset during SEND
    add(0,0,0,0,8'h5A, 0,0,0,8'h00,0);
    add(0,1,0,0,8'h5A, 1,0,1,8'h00,0);
    add(0,1,0,0,8'h5A, 0,0,1,8'h00,0);
    add(0,1,0,1,8'h00, 0,1,1,8'h5A,0);
    add(0,0,0,0,8'h11, 0,0,0,8'h5A,1);
    add(0,0,0,0,8'h11, 1,0,1,8'h5A,1);
    add(0,0,0,0,8'h11, 0,0,1,8'h5A,1);
    add(0,0,1,1,8'h00, 0,1,1,8'h11,1);   // pause raised in SEND, frame completes
    add(0,0,1,0,8'h00, 0,0,0,8'h11,2);
    add(0,0,1,0,8'h00, 0,0,0,8'h11,2);
    add(0,0,0,0,8'h22, 0,0,0,8'h11,2);   // pause falls
    add(0,0,0,0,8'h22, 1,0,1,8'h11,2);
    add(0,0,0,0,8'h22, 0,0,1,8'h11,2);
    add(0,0,0,1,8'h00, 0,1,1,8'h22,2);   // done at k, FIFO not empty
    add(0,0,0,0,8'h33, 0,0,0,8'h22,3);
    add(0,1,0,0,8'h33, 1,0,1,8'h22,3);   // read at k+2
    add(0,1,0,0,8'h33, 0,0,1,8'h22,3);
    add(0,1,0,1,8'h00, 0,1,1,8'h33,3);
    add(0,1,0,0,8'h00, 0,0,0,8'h33,4);

    @(negedge CLK);
    @(negedge CLK);
    foreach (tbl[i]) begin
      chk($sformatf("a_rd_req[%0d]", i), 32'(RD_a), 32'(tbl[i].e_rd));
      chk($sformatf("a_txen[%0d]", i), 32'(TxEn_a), 32'(tbl[i].e_en));
      chk($sformatf("a_busy[%0d]", i), 32'(Busy_a), 32'(tbl[i].e_busy));
      chk($sformatf("a_tx_dat[%0d]", i), 32'(Tdat_a), 32'(tbl[i].e_dat));
      chk($sformatf("a_byte_cnt[%0d]", i), 32'(Cnt_a), 32'(tbl[i].e_cnt));
      RST_a = tbl[i].rst; Empty_a = tbl[i].empty; Pause_a = tbl[i].pause;
      Done_a = tbl[i].done; Fdat_a = tbl[i].dat;
      @(negedge CLK);
    end
    Empty_a = 1; Done_a = 0; Pause_a = 0;

    // two queued 9-bit words, RD_LAT=3
    reset_b();
    fifo_q.push_back(9'h1FF);
    fifo_q.push_back(9'h003);
    drain_b(0, 200);
    chk("b_first_txen_cycle", 32'(first_en), 32'(5));
    chk("b_rd_pulses", 32'(rd_pulses), 32'(2));
    chk("b_fall_to_next_rd", 32'(rd_after_fall), 32'(GAP_EXP + 1));
    chk("b_two_frames_cnt", 32'(Cnt_b), 32'(2));

    // 17 frames wrap a 4-bit counter to 1
    reset_b();
    for (int i = 0; i < 17; i++) fifo_q.push_back(9'($urandom));
    drain_b(1, 1000);
    chk("b_wrap_cnt", 32'(Cnt_b), 32'(1));

    // random traffic, pause and stray done pulses
    reset_b();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 6) fifo_q.push_back(9'($urandom));
      if ($urandom_range(0, 15) == 0) pause_drive = ~pause_drive;
      step_b(1);
    end
    pause_drive = 0;
    drain_b(1, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
